// File: rtl/afe_l2_arbiter.sv
// afe_l2_arbiter: round-robin arbiter with burst lock that shares the uDMA
// L2 write port between the readout L2 channels. A single registered output
// beat with valid/ready handshake drives the L2 port at full throughput.
module afe_l2_arbiter #(
  parameter int L2_NUM_CHS     = 8,
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_WIDTH    = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [L2_NUM_CHS-1:0]                ch_en_i,
  input  logic [L2_NUM_CHS-1:0]                ch_req_i,
  input  logic [L2_NUM_CHS*L2_AWIDTH_NOAL-1:0] ch_addr_i,
  input  logic [L2_NUM_CHS*DATA_WIDTH-1:0]     ch_data_i,
  input  logic [L2_NUM_CHS*2-1:0]              ch_size_i,
  output logic [L2_NUM_CHS-1:0]                ch_gnt_o,
  input  logic [BURST_WIDTH-1:0]               cfg_burst_i,
  output logic                                 l2_valid_o,
  input  logic                                 l2_ready_i,
  output logic [L2_AWIDTH_NOAL-1:0]            l2_addr_o,
  output logic [DATA_WIDTH-1:0]                l2_data_o,
  output logic [1:0]                           l2_size_o,
  output logic [4:0]                           l2_chid_o,
  output logic                                 busy_o
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                   state_reg, state_next;
  logic [4:0]               owner_reg, owner_next;
  logic [4:0]               rr_ptr_reg, rr_ptr_next;
  logic [BURST_WIDTH-1:0]   beat_cnt_reg, beat_cnt_next;

  logic [L2_AWIDTH_NOAL-1:0] ch_addr_arr [L2_NUM_CHS];
  logic [DATA_WIDTH-1:0]     ch_data_arr [L2_NUM_CHS];
  logic [1:0]                ch_size_arr [L2_NUM_CHS];

  logic [L2_NUM_CHS-1:0]   elig;
  logic                    load;
  logic [BURST_WIDTH-1:0]  eff_burst;
  logic [BURST_WIDTH-1:0]  beat_cnt_inc;
  logic [L2_NUM_CHS-1:0]   owner_oh;
  logic                    owner_elig;
  logic                    owner_en;
  logic                    owner_hit;
  logic [L2_NUM_CHS-1:0]   rot;
  logic [4:0]              rr_off;
  logic [5:0]              rr_sum;
  logic [4:0]              rr_sel;
  logic [4:0]              sel;
  logic [4:0]              sel_ptr_next;
  logic [L2_AWIDTH_NOAL-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic [1:0]                sel_size;

  // Split the flattened per-channel buses into indexable arrays.
  for (genvar gi = 0; gi < L2_NUM_CHS; gi++) begin : g_unpack
    assign ch_addr_arr[gi] = ch_addr_i[gi*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
    assign ch_data_arr[gi] = ch_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign ch_size_arr[gi] = ch_size_i[gi*2 +: 2];
  end

  assign elig         = ch_req_i & ch_en_i;
  assign load         = (elig != '0) && (!l2_valid_o || l2_ready_i);
  assign eff_burst    = (cfg_burst_i == '0) ? BURST_WIDTH'(1) : cfg_burst_i;
  assign beat_cnt_inc = beat_cnt_reg + BURST_WIDTH'(1);
  assign busy_o       = l2_valid_o || (state_reg == LOCKED);

  // Decode the owner index once so eligibility/enable lookups stay narrow.
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < L2_NUM_CHS; i++) begin
      if (owner_reg == 5'(i)) owner_oh[i] = 1'b1;
    end
  end

  assign owner_elig = |(elig & owner_oh);
  assign owner_en   = |(ch_en_i & owner_oh);
  assign owner_hit  = (state_reg == LOCKED) && owner_elig && (beat_cnt_reg < eff_burst);

  // Round-robin search: rotate so rr_ptr lands at bit 0, take the first set bit.
  always_comb begin
    rot    = L2_NUM_CHS'({elig, elig} >> rr_ptr_reg);
    rr_off = '0;
    for (int i = L2_NUM_CHS - 1; i >= 0; i--) begin
      if (rot[i]) rr_off = 5'(i);
    end
  end

  assign rr_sum       = {1'b0, rr_ptr_reg} + {1'b0, rr_off};
  assign rr_sel       = (rr_sum >= 6'(L2_NUM_CHS)) ? 5'(rr_sum - 6'(L2_NUM_CHS)) : rr_sum[4:0];
  assign sel          = owner_hit ? owner_reg : rr_sel;
  assign sel_ptr_next = (sel == 5'(L2_NUM_CHS - 1)) ? 5'd0 : sel + 5'd1;

  // One-hot grant pulse and source mux for the selected channel.
  always_comb begin
    ch_gnt_o = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_size = '0;
    for (int i = 0; i < L2_NUM_CHS; i++) begin
      if (sel == 5'(i)) begin
        ch_gnt_o[i] = load;
        sel_addr    = ch_addr_arr[i];
        sel_data    = ch_data_arr[i];
        sel_size    = ch_size_arr[i];
      end
    end
  end

  // Next-state logic: burst lock bookkeeping and round-robin pointer update.
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    if (load) begin
      if (owner_hit) begin
        beat_cnt_next = beat_cnt_inc;
        if (beat_cnt_inc == eff_burst) state_next = IDLE;
      end else begin
        state_next    = LOCKED;
        owner_next    = sel;
        beat_cnt_next = BURST_WIDTH'(1);
        rr_ptr_next   = sel_ptr_next;
      end
    end else if ((state_reg == LOCKED) && !owner_en) begin
      // Owner was disabled: drop the lock without waiting for a load.
      state_next    = IDLE;
      beat_cnt_next = '0;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // Output beat register: load a new beat, hold under backpressure, drain on ready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      l2_valid_o <= 1'b0;
      l2_addr_o  <= '0;
      l2_data_o  <= '0;
      l2_size_o  <= '0;
      l2_chid_o  <= '0;
    end else if (load) begin
      l2_valid_o <= 1'b1;
      l2_addr_o  <= sel_addr;
      l2_data_o  <= sel_data;
      l2_size_o  <= sel_size;
      l2_chid_o  <= sel;
    end else if (l2_ready_i) begin
      l2_valid_o <= 1'b0;
    end
  end

endmodule
